// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Accepts one byte per grant, launches the UART, waits for done_tx, then applies an optional gap.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 32768
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        start,
    output logic [DATA_WIDTH-1:0]       tx_data_in,
    input  logic                        done_tx,
    input  logic                        tx_active,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        busy,
    output logic                        timeout_err,
    input  logic                        clr_err,
    output logic [15:0]                 frame_count
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] idx;
    logic            found;
    logic            accept;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;
    logic            wd_expire;
    logic            frame_end;
    logic [7:0]      gap_cnt;
    logic            unused_status;

    // tx_active is informational only; sequencing relies solely on done_tx.
    assign unused_status = tx_active;

    // Rotating priority: the search starts just after the last granted requester.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign accept = (state == IDLE) && found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign start     = (state == LAUNCH);
    assign busy      = (state != IDLE);
    assign wd_hit    = (wd_cnt == WD_LAST);
    assign frame_end = (state == BUSY) && done_tx;
    // A done_tx landing on the expiry cycle still counts as a good frame.
    assign wd_expire = (state == BUSY) && wd_hit && !done_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = BUSY;
            end
            BUSY: begin
                if (done_tx || wd_hit) begin
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_in  <= '0;
            grant_id    <= '0;
            last        <= ID_W'(N_REQ - 1);
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            // tx_data_in is only written on accept, so it holds until done_tx.
            if (accept) begin
                tx_data_in <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                grant_id   <= winner;
                last       <= winner;
            end

            if (state == LAUNCH) begin
                wd_cnt <= '0;
            end else if (state == BUSY) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            if (state == GAP) begin
                gap_cnt <= gap_cnt + 8'd1;
            end else begin
                gap_cnt <= '0;
            end

            if (frame_end) begin
                frame_count <= frame_count + 16'd1;
            end

            // Expiry outranks a simultaneous clear so a fresh fault is never lost.
            if (wd_expire) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected grants, a monitor checks each start.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            start;
    logic [DW-1:0]   tx_data_in;
    logic            done_tx;
    logic            tx_active;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;
    logic            clr_err;
    logic [15:0]     frame_count;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N),
        .DATA_WIDTH(DW),
        .GAP_CYCLES(5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .start(start),
        .tx_data_in(tx_data_in),
        .done_tx(done_tx),
        .tx_active(tx_active),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_err(timeout_err),
        .clr_err(clr_err),
        .frame_count(frame_count)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic uart_en;
    int   uart_delay;
    int   poke_req;
    int   poke_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_tx(input logic [1:0] id, input logic [7:0] data);
        exp_q.push_back({id, data});
    endtask

    // Stimulus moves 1 time unit after the falling edge; the monitor samples on the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_start"},       32'(start),       32'd0);
        check({tag, "_tx_data"},     32'(tx_data_in),  32'd0);
        check({tag, "_req_ready"},   32'(req_ready),   32'd0);
        check({tag, "_grant_id"},    32'(grant_id),    32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    // Holds the pattern until n accepts have happened, then drops valid in the LAUNCH cycle.
    task automatic run_reqs(input logic [N-1:0] v, input int n);
        int got = 0;
        int cyc = 0;
        req_valid = v;
        #1;
        while (got < n && cyc < 3000) begin
            if (|(req_valid & req_ready)) got++;
            if (got < n) begin
                tick();
                cyc++;
            end
        end
        tick();
        req_valid = '0;
        check("accepts", 32'(got), 32'(n));
    endtask

    task automatic drain();
        int cyc = 0;
        while ((busy || exp_q.size() != 0) && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    // UART model: answers each start with done_tx in BUSY cycle uart_delay, and checks the byte held.
    initial begin : uart_model
        int         pend;
        logic [7:0] cap;
        done_tx   = 1'b0;
        tx_active = 1'b0;
        pend      = 0;
        poke_ack  = 0;
        cap       = '0;
        forever begin
            @(posedge clk);
            #1;
            done_tx = 1'b0;
            if (rst) begin
                pend      = 0;
                tx_active = 1'b0;
            end else if (poke_req != poke_ack) begin
                poke_ack = poke_req;
                done_tx  = 1'b1;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    check("loopback_rx", 32'(tx_data_in), 32'(cap));
                    done_tx   = 1'b1;
                    tx_active = 1'b0;
                end
            end else if (start && uart_en) begin
                cap       = tx_data_in;
                tx_active = 1'b1;
                pend      = uart_delay;
            end
        end
    end

    initial begin : monitor
        logic outstanding;
        logic prev_err;
        exp_t e;
        outstanding = 1'b0;
        prev_err    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 1'b0;
                prev_err    = 1'b0;
            end else begin
                if (start) begin
                    check("start_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("tx_data", 32'(tx_data_in), 32'(e.data));
                        check("grant_id", 32'(grant_id), 32'(e.id));
                    end
                end
                if ((done_tx && busy) || (timeout_err && !prev_err)) outstanding = 1'b0;
                if (|(req_valid & req_ready)) begin
                    check("single_outstanding", 32'(outstanding), 32'd0);
                    outstanding = 1'b1;
                end
                prev_err = timeout_err;
            end
        end
    end

    initial begin : time_limit
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int n;
        int cnt;
        int busy_drop;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        clr_err    = 1'b0;
        uart_en    = 1'b1;
        uart_delay = 3;
        poke_req   = 0;
        tick();
        tick();
        check_reset_vals("por");
        rst = 1'b0;
        tick();

        // Single requester: ready this cycle, start the next.
        req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
        expect_tx(2'd0, 8'hA5);
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("single_start", 32'(start), 32'd1);
        check("single_ready_after", 32'(req_ready), 32'd0);
        drain();
        check("single_frames", 32'(frame_count), 32'd1);
        check("single_grant", 32'(grant_id), 32'd0);

        // done_tx while IDLE must not count.
        poke_req++;
        tick();
        tick();
        check("idle_done_ignored", 32'(frame_count), 32'd1);

        // All four held valid: rotation 0,1,2,3,0.
        rst = 1'b1;
        tick();
        check_reset_vals("rst2");
        rst = 1'b0;
        tick();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        expect_tx(2'd0, 8'h11);
        expect_tx(2'd1, 8'h22);
        expect_tx(2'd2, 8'h33);
        expect_tx(2'd3, 8'h44);
        expect_tx(2'd0, 8'h11);
        run_reqs(4'b1111, 5);
        drain();
        check("rr_frames", 32'(frame_count), 32'd5);

        // Fairness from last=2 with pattern 1011: 3, 0, 1.
        expect_tx(2'd2, 8'h33);
        run_reqs(4'b0100, 1);
        drain();
        expect_tx(2'd3, 8'h44);
        expect_tx(2'd0, 8'h11);
        expect_tx(2'd1, 8'h22);
        run_reqs(4'b1011, 3);
        drain();
        check("fair_last_grant", 32'(grant_id), 32'd1);
        check("fair_frames", 32'(frame_count), 32'd9);

        // Gap: done_tx in cycle k, next ready in cycle k+6 (five idle GAP cycles between).
        expect_tx(2'd0, 8'h11);
        expect_tx(2'd0, 8'h11);
        req_valid = 4'b0001;
        cnt = 0;
        while (!(done_tx && busy) && cnt < 200) begin
            tick();
            cnt++;
        end
        check("gap_done_seen", 32'(done_tx && busy), 32'd1);
        cnt = 0;
        busy_drop = 0;
        do begin
            tick();
            cnt++;
            if (req_ready == '0 && !busy) busy_drop++;
        end while (req_ready == '0 && cnt < 50);
        check("gap_ready_delay", 32'(cnt), 32'd6);
        check("gap_busy_held", 32'(busy_drop), 32'd0);
        tick();
        req_valid = '0;
        drain();
        check("gap_frames", 32'(frame_count), 32'd11);

        // Watchdog: no done_tx, flag appears after BUSY cycle 100.
        uart_en = 1'b0;
        expect_tx(2'd1, 8'h22);
        run_reqs(4'b0010, 1);
        n = 0;
        while (!timeout_err && n < 300) begin
            tick();
            n++;
        end
        check("wd_expiry_cycle", 32'(n), 32'd101);
        check("wd_frames_kept", 32'(frame_count), 32'd11);
        drain();
        check("wd_sticky", 32'(timeout_err), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("wd_cleared", 32'(timeout_err), 32'd0);

        // Expiry while clr_err is held: expiry wins for one cycle.
        clr_err = 1'b1;
        expect_tx(2'd1, 8'h22);
        run_reqs(4'b0010, 1);
        n = 0;
        while (!timeout_err && n < 300) begin
            tick();
            n++;
        end
        check("wd_vs_clr_cycle", 32'(n), 32'd101);
        tick();
        check("wd_vs_clr_after", 32'(timeout_err), 32'd0);
        clr_err = 1'b0;
        drain();

        // done_tx exactly on the expiry cycle counts as a completed frame.
        uart_en    = 1'b1;
        uart_delay = 100;
        expect_tx(2'd3, 8'h44);
        run_reqs(4'b1000, 1);
        drain();
        check("wd_coincident_err", 32'(timeout_err), 32'd0);
        check("wd_coincident_frames", 32'(frame_count), 32'd12);
        uart_delay = 3;

        // Reset mid-BUSY takes effect without a clock edge; next grant restarts at requester 0.
        uart_en = 1'b0;
        expect_tx(2'd2, 8'h33);
        run_reqs(4'b0100, 1);
        tick();
        tick();
        tick();
        check("midbusy_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async");
        tick();
        rst = 1'b0;
        uart_en = 1'b1;
        tick();
        expect_tx(2'd0, 8'h11);
        run_reqs(4'b1111, 1);
        drain();
        check("post_rst_frames", 32'(frame_count), 32'd1);
        check("post_rst_grant", 32'(grant_id), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter among N_REQ byte producers.
- Accepts one byte per requester handshake and drives the UART `start`/`tx_data_in` pulse interface.
- Waits for `done_tx` before accepting the next byte, then enforces an optional inter-frame gap.
- Sits between producer blocks and the UART instance; a watchdog flags a transmitter that never completes.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width; matches the UART.
- GAP_CYCLES, 0, idle clocks inserted after `done_tx` before the next grant (0..255).
- TIMEOUT_CYCLES, 32768, max clocks in BUSY without `done_tx` (> one frame: 26042 clocks at 50 MHz / 19200 baud).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  requester i has a byte pending.
- req_data  in  N_REQ*DATA_WIDTH  byte of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  N_REQ  one-hot accept; transfer when req_valid[i] && req_ready[i].
- start  out  1  one-cycle launch pulse to the UART.
- tx_data_in  out  DATA_WIDTH  byte to the UART; held stable from the start pulse until `done_tx`.
- done_tx  in  1  UART frame-complete pulse.
- tx_active  in  1  UART busy indicator; status only.
- grant_id  out  $clog2(N_REQ)  index of the last accepted requester.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky watchdog flag.
- clr_err  in  1  synchronous clear of timeout_err.
- frame_count  out  16  total frames completed by `done_tx`; wraps at 0xFFFF -> 0.

Behaviour:
- Reset values (async, rst=1): state=IDLE, start=0, tx_data_in=0, req_ready=0, grant_id=0, busy=0, timeout_err=0, frame_count=0, RR pointer last=N_REQ-1 (requester 0 has highest priority first).
- States:
  - IDLE -> LAUNCH when any req_valid.
  - LAUNCH -> BUSY (always, one cycle).
  - BUSY -> GAP on `done_tx`, or on watchdog expiry.
  - GAP -> IDLE after GAP_CYCLES clocks; skip GAP if GAP_CYCLES=0 (BUSY -> IDLE directly).
- Arbitration (IDLE only):
  - Winner w = first i with req_valid[i], searching last+1, last+2, ... mod N_REQ.
  - req_ready is combinational: onehot(w) when state==IDLE && |req_valid, else 0.
  - On the accept edge: latch req_data[w] into tx_data_in, grant_id<=w, last<=w.
- Requester rule: req_data must stay stable while req_valid is high; dropping valid before ready is allowed (no transfer occurs).
- LAUNCH: start=1 for exactly one cycle, the cycle after the accept edge.
- BUSY:
  - Watchdog counter cleared on entry and incremented each clock.
  - `done_tx` -> frame_count+1 and leave BUSY.
  - Counter reaches TIMEOUT_CYCLES-1 without `done_tx` -> timeout_err<=1 and leave BUSY; frame_count unchanged.
  - `done_tx` on the same cycle as expiry counts as done: no error.
- GAP: counter runs 0..GAP_CYCLES-1, then IDLE. Earliest next req_ready is GAP_CYCLES cycles after leaving BUSY.
- Throughput: accept -> start is 1 cycle; `done_tx` at cycle k -> req_ready possible at k+1+GAP_CYCLES.
- Edge cases:
  - `done_tx` outside BUSY is ignored.
  - start is never asserted outside LAUNCH.
  - clr_err and expiry in the same cycle: expiry wins (flag stays set).
  - rst mid-frame aborts immediately to reset values; the UART is not informed.
  - A new request on the same cycle as `done_tx` is not accepted until IDLE.

Test Plan:
- Single requester: req_valid=0001, data 0xA5, UART in loopback -> req_ready[0] one cycle, start next cycle, tx_data_in=0xA5, loopback rx_data_out=0xA5, frame_count=1, grant_id=0.
- All four requesters held valid with 0x11/0x22/0x33/0x44 -> grant order 0,1,2,3,0; tx bytes 0x11,0x22,0x33,0x44,0x11; never two accepts without an intervening `done_tx`.
- Fairness: last grant=2, req_valid=1011 -> next grant 3, then 0, then 1.
- GAP_CYCLES=5 -> exactly 5 cycles between the `done_tx` cycle+1 and the next req_ready; busy high throughout.
- Watchdog: TIMEOUT_CYCLES=100, done_tx tied 0 -> timeout_err rises at cycle 100 of BUSY, FSM returns to IDLE, frame_count unchanged; clr_err clears the flag.
- Reset mid-BUSY -> all outputs return to reset values asynchronously; the next request goes to requester 0 first.
